// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the TPU data-SRAM arbitration slice.
//   - owner encoding presented on sram_port_arbiter.owner
//   - requester index order used by the round-robin pointer
//   - default address/data widths
//   - small helpers for the round-robin rotation
// ---------------------------------------------------------------------------
package tpu_pkg;

    localparam int unsigned ADDRW_DEF = 10;
    localparam int unsigned DATAW_DEF = 16;

    // Owner encoding (also the FSM state: NONE is the idle state).
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_HOST = 2'd1;
    localparam logic [1:0] OWN_FILL = 2'd2;
    localparam logic [1:0] OWN_WB   = 2'd3;

    // Requester index used by the rr pointer and one-hot grant vectors.
    localparam logic [1:0] IDX_HOST = 2'd0;
    localparam logic [1:0] IDX_FILL = 2'd1;
    localparam logic [1:0] IDX_WB   = 2'd2;

    // Next requester index in round-robin order host -> fill -> wb -> host.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= IDX_WB) ? IDX_HOST : idx + 2'd1;
    endfunction

    // One-hot grant (bit 0 host, 1 fill, 2 wb) to owner code.
    function automatic logic [1:0] oh_to_owner(input logic [2:0] oh);
        logic [1:0] code;
        code = OWN_NONE;
        if (oh[IDX_HOST]) code = OWN_HOST;
        if (oh[IDX_FILL]) code = OWN_FILL;
        if (oh[IDX_WB])   code = OWN_WB;
        return code;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick3
// Combinational 3-way round-robin picker.
//   req_i  : request vector, bit 0 host, bit 1 fill, bit 2 wb
//   ptr_i  : index searched first (0..2; 3 is treated as 0)
//   gnt_o  : one-hot grant of the first requester at or after ptr_i
// ---------------------------------------------------------------------------
module rr_pick3
    import tpu_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] gnt_o
);

    logic [1:0] idx;

    always_comb begin
        gnt_o = '0;
        idx   = (ptr_i > IDX_WB) ? IDX_HOST : ptr_i;
        for (int unsigned i = 0; i < 3; i++) begin
            if ((gnt_o == '0) && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
            end
            idx = rr_next(idx);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
// Arbitrates the single-port data SRAM between the host loader (writes),
// the queue fill path (reads) and write-back (writes) with a req/gnt
// handshake, round-robin fairness and a burst lock of at most BURST_MAX
// beats while others wait.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   host_req/addr/wdata -> host_gnt  host write beats
//   fill_req/addr       -> fill_gnt  fill read beats
//   fill_rvalid, fill_rdata          read return, 1+SRAM_RD_LAT after accept
//   wb_req/addr/wdata   -> wb_gnt    write-back write beats
//   sram_addr/wdata/wr               registered SRAM command
//   sram_rdata                       SRAM read data
//   owner                            0 none, 1 host, 2 fill, 3 wb
//
// Optional build macro ARB_STATS_EN adds stat_clr and saturating per-
// requester beat counters stat_host, stat_fill, stat_wb.
// ---------------------------------------------------------------------------
module sram_port_arbiter
    import tpu_pkg::*;
#(
    parameter int unsigned DATAW       = DATAW_DEF,
    parameter int unsigned ADDRW       = ADDRW_DEF,
    parameter int unsigned BURST_MAX   = 8,
    parameter int unsigned SRAM_RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             host_req,
    input  logic [ADDRW-1:0] host_addr,
    input  logic [DATAW-1:0] host_wdata,
    output logic             host_gnt,
    input  logic             fill_req,
    input  logic [ADDRW-1:0] fill_addr,
    output logic             fill_gnt,
    output logic             fill_rvalid,
    output logic [DATAW-1:0] fill_rdata,
    input  logic             wb_req,
    input  logic [ADDRW-1:0] wb_addr,
    input  logic [DATAW-1:0] wb_wdata,
    output logic             wb_gnt,
    output logic [ADDRW-1:0] sram_addr,
    output logic [DATAW-1:0] sram_wdata,
    output logic             sram_wr,
    input  logic [DATAW-1:0] sram_rdata,
`ifdef ARB_STATS_EN
    input  logic             stat_clr,
    output logic [15:0]      stat_host,
    output logic [15:0]      stat_fill,
    output logic [15:0]      stat_wb,
`endif
    output logic [1:0]       owner
);

    localparam int unsigned   RET_DEPTH  = 1 + SRAM_RD_LAT;
    localparam int unsigned   BW         = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX);

    logic [1:0]           owner_q, owner_d;
    logic [1:0]           rr_q, rr_d;
    logic [BW-1:0]        burst_q, burst_d;
    logic [ADDRW-1:0]     sram_addr_q;
    logic [DATAW-1:0]     sram_wdata_q;
    logic                 sram_wr_q;
    logic [RET_DEPTH-1:0] ret_q, ret_d;

    logic [2:0] req_v, own_oh, others, pick_req, pick_gnt, gnt_raw, gnt;
    logic [1:0] own_idx, pick_ptr;
    logic       own_req;
    logic [ADDRW-1:0] addr_sel;
    logic [DATAW-1:0] wdata_sel;

    // The picker serves two cases: from idle it searches all requests from
    // rr_q; while owned it searches only the other requesters, starting
    // after the owner, for a same-cycle handover.
    always_comb begin
        req_v    = {wb_req, fill_req, host_req};
        own_idx  = owner_q - 2'd1;
        own_oh   = (owner_q == OWN_NONE) ? 3'b000 : (3'b001 << own_idx);
        own_req  = |(req_v & own_oh);
        others   = req_v & ~own_oh;
        pick_req = (owner_q == OWN_NONE) ? req_v : others;
        pick_ptr = (owner_q == OWN_NONE) ? rr_q : rr_next(own_idx);
    end

    rr_pick3 u_pick (
        .req_i (pick_req),
        .ptr_i (pick_ptr),
        .gnt_o (pick_gnt)
    );

    always_comb begin
        gnt_raw = '0;
        owner_d = owner_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        if (owner_q == OWN_NONE) begin
            gnt_raw = pick_gnt;
            if (|pick_gnt) begin
                owner_d = oh_to_owner(pick_gnt);
                burst_d = BW'(1);
            end
        end else if (own_req && (burst_q < BURST_LAST)) begin
            gnt_raw = own_oh;
            burst_d = burst_q + BW'(1);
        end else if (|others) begin
            // Owner released or burst exhausted with others waiting.
            gnt_raw = pick_gnt;
            owner_d = oh_to_owner(pick_gnt);
            burst_d = BW'(1);
            rr_d    = rr_next(own_idx);
        end else if (own_req) begin
            // Burst exhausted but nobody else waiting: keep going.
            gnt_raw = own_oh;
            burst_d = BW'(1);
        end else begin
            owner_d = OWN_NONE;
            burst_d = '0;
            rr_d    = rr_next(own_idx);
        end
    end

    // Grants are combinational; hold them low while reset is asserted.
    assign gnt = rst_n ? gnt_raw : 3'b000;

    always_comb begin
        addr_sel  = host_addr;
        wdata_sel = host_wdata;
        if (gnt[IDX_FILL]) begin
            addr_sel = fill_addr;
        end
        if (gnt[IDX_WB]) begin
            addr_sel  = wb_addr;
            wdata_sel = wb_wdata;
        end
        ret_d    = ret_q << 1;
        ret_d[0] = gnt[IDX_FILL];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_NONE;
            rr_q         <= IDX_HOST;
            burst_q      <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_wr_q    <= 1'b0;
            ret_q        <= '0;
        end else begin
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            burst_q   <= burst_d;
            sram_wr_q <= gnt[IDX_HOST] | gnt[IDX_WB];
            ret_q     <= ret_d;
            if (|gnt) begin
                sram_addr_q <= addr_sel;
            end
            if (gnt[IDX_HOST] | gnt[IDX_WB]) begin
                sram_wdata_q <= wdata_sel;
            end
        end
    end

    assign host_gnt    = gnt[IDX_HOST];
    assign fill_gnt    = gnt[IDX_FILL];
    assign wb_gnt      = gnt[IDX_WB];
    assign sram_addr   = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;
    assign sram_wr     = sram_wr_q;
    assign owner       = owner_q;
    assign fill_rvalid = ret_q[RET_DEPTH-1];
    // The SRAM data is live in the return cycle; pass it straight through.
    assign fill_rdata  = ret_q[RET_DEPTH-1] ? sram_rdata : '0;

`ifdef ARB_STATS_EN
    logic [15:0] stat_q [3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (stat_clr) begin
                    stat_q[i] <= '0;
                end else if (gnt[i] && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    assign stat_host = stat_q[IDX_HOST];
    assign stat_fill = stat_q[IDX_FILL];
    assign stat_wb   = stat_q[IDX_WB];
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        host_req, fill_req, wb_req;
    logic [9:0]  host_addr, fill_addr, wb_addr;
    logic [15:0] host_wdata, wb_wdata;
    logic        host_gnt, fill_gnt, wb_gnt;
    logic        fill_rvalid;
    logic [15:0] fill_rdata;
    logic [9:0]  sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_wr;
    logic [15:0] sram_rdata;
    logic [1:0]  owner;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t     rdq[$];
    logic [15:0] exp_mem  [0:1023];
    logic [15:0] sram_mem [0:1023];

    sram_port_arbiter #(
        .DATAW       (16),
        .ADDRW       (10),
        .BURST_MAX   (8),
        .SRAM_RD_LAT (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .fill_req    (fill_req),
        .fill_addr   (fill_addr),
        .fill_gnt    (fill_gnt),
        .fill_rvalid (fill_rvalid),
        .fill_rdata  (fill_rdata),
        .wb_req      (wb_req),
        .wb_addr     (wb_addr),
        .wb_wdata    (wb_wdata),
        .wb_gnt      (wb_gnt),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_wr     (sram_wr),
        .sram_rdata  (sram_rdata),
        .owner       (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one cycle from registered command to read data.
    always @(posedge clk) begin
        if (sram_wr) sram_mem[sram_addr] <= sram_wdata;
        sram_rdata <= sram_mem[sram_addr];
    end

    task automatic cyc_begin();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sample point; accepted beats update the reference memory and
    // fill beats push their expected return (data, cycle) to the scoreboard.
    task automatic cyc_sample();
        @(negedge clk);
        if (host_req && host_gnt) exp_mem[host_addr] = host_wdata;
        if (wb_req && wb_gnt)     exp_mem[wb_addr]   = wb_wdata;
        if (fill_req && fill_gnt) rdq.push_back('{data: exp_mem[fill_addr], due: cyc + 2});
    endtask

    task automatic set_reqs(input logic h, input logic f, input logic w);
        host_req = h;
        fill_req = f;
        wb_req   = w;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_reqs(0, 0, 0);
        cyc_begin();
        cyc_begin();
        @(negedge clk);
        checks++;
        if ({host_gnt, fill_gnt, wb_gnt, sram_wr, fill_rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b want 00000", {host_gnt, fill_gnt, wb_gnt, sram_wr, fill_rvalid});
        end
        checks++;
        if (sram_addr !== 10'h0 || sram_wdata !== 16'h0 || fill_rdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want 0", sram_addr, sram_wdata, fill_rdata);
        end
        checks++;
        if (owner !== 2'd0) begin
            failures++;
            $display("FAIL reset_owner got %0d want 0", owner);
        end
        cyc_begin();
        set_reqs(1, 1, 1);
        @(negedge clk);
        checks++;
        if ({wb_gnt, fill_gnt, host_gnt} !== 3'b000) begin
            failures++;
            $display("FAIL reset_gnt got %b want 000", {wb_gnt, fill_gnt, host_gnt});
        end
        cyc_begin();
        set_reqs(0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_host_write();
        cyc_begin();
        host_req = 1'b1; host_addr = 10'h005; host_wdata = 16'h1234;
        cyc_sample();
        checks++;
        if ({wb_gnt, fill_gnt, host_gnt} !== 3'b001) begin
            failures++;
            $display("FAIL host_gnt got %b want 001", {wb_gnt, fill_gnt, host_gnt});
        end
        cyc_begin();
        host_req = 1'b0;
        cyc_sample();
        checks++;
        if (sram_addr !== 10'h005 || sram_wdata !== 16'h1234 || sram_wr !== 1'b1) begin
            failures++;
            $display("FAIL host_cmd got addr=%h wdata=%h wr=%b want 005 1234 1", sram_addr, sram_wdata, sram_wr);
        end
        checks++;
        if (owner !== 2'd1) begin
            failures++;
            $display("FAIL host_owner got %0d want 1", owner);
        end
        cyc_begin();
        cyc_sample();
        checks++;
        if (sram_wr !== 1'b0 || sram_addr !== 10'h005 || owner !== 2'd0) begin
            failures++;
            $display("FAIL host_idle got wr=%b addr=%h owner=%0d want 0 005 0", sram_wr, sram_addr, owner);
        end
    endtask

    task automatic test_fill_latency();
        logic        rv_exp;
        logic [15:0] ed;
        int          rv_cnt;
        int          first_rv;
        int          last_rv;
        rv_cnt = 0; first_rv = -1; last_rv = -1;
        // one read of 0x005, then four back-to-back reads of 0x010..0x013
        for (int i = 0; i < 11; i++) begin
            cyc_begin();
            fill_req  = (i == 0) || (i >= 4 && i < 8);
            fill_addr = (i == 0) ? 10'h005 : 10'(10'h010 + i - 4);
            cyc_sample();
            if (fill_req) begin
                checks++;
                if (fill_gnt !== 1'b1) begin
                    failures++;
                    $display("FAIL fill_gnt step=%0d got %b want 1", i, fill_gnt);
                end
            end
            rv_exp = (rdq.size() > 0) && (rdq[0].due == cyc);
            ed     = rv_exp ? rdq[0].data : 16'h0;
            checks++;
            if (fill_rvalid !== rv_exp || (rv_exp && fill_rdata !== ed)) begin
                failures++;
                $display("FAIL fill_return cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h", cyc, fill_rvalid, fill_rdata, rv_exp, ed);
            end
            if (rv_exp) void'(rdq.pop_front());
            if (i >= 4 && fill_rvalid === 1'b1) begin
                rv_cnt++;
                if (first_rv < 0) first_rv = cyc;
                last_rv = cyc;
            end
            if (i == 2) begin
                checks++;
                if (fill_rdata !== 16'h1234) begin
                    failures++;
                    $display("FAIL fill_first_data got %h want 1234", fill_rdata);
                end
            end
        end
        checks++;
        if (rv_cnt != 4 || last_rv - first_rv != 3) begin
            failures++;
            $display("FAIL fill_b2b got count=%0d span=%0d want 4 3", rv_cnt, last_rv - first_rv);
        end
    endtask

    task automatic test_raw();
        logic        rv_exp;
        logic [15:0] ed;
        logic [2:0]  exp_g [5] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 5; i++) begin
            cyc_begin();
            host_req = (i == 0); host_addr = 10'h020; host_wdata = 16'hBEEF;
            fill_req = (i == 1); fill_addr = 10'h020;
            cyc_sample();
            checks++;
            if ({wb_gnt, fill_gnt, host_gnt} !== exp_g[i]) begin
                failures++;
                $display("FAIL raw_gnt step=%0d got %b want %b", i, {wb_gnt, fill_gnt, host_gnt}, exp_g[i]);
            end
            rv_exp = (rdq.size() > 0) && (rdq[0].due == cyc);
            ed     = rv_exp ? rdq[0].data : 16'h0;
            checks++;
            if (fill_rvalid !== rv_exp || (rv_exp && fill_rdata !== ed)) begin
                failures++;
                $display("FAIL raw_return cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h", cyc, fill_rvalid, fill_rdata, rv_exp, ed);
            end
            if (rv_exp) void'(rdq.pop_front());
        end
    endtask

    task automatic test_lone_owner();
        for (int i = 0; i < 21; i++) begin
            cyc_begin();
            wb_req   = (i < 20);
            wb_addr  = 10'(10'h300 + i);
            wb_wdata = 16'(16'hA000 + i);
            cyc_sample();
            if (i < 20) begin
                checks++;
                if ({wb_gnt, fill_gnt, host_gnt} !== 3'b100) begin
                    failures++;
                    $display("FAIL lone_gnt step=%0d got %b want 100", i, {wb_gnt, fill_gnt, host_gnt});
                end
                checks++;
                if (owner !== ((i == 0) ? 2'd0 : 2'd3)) begin
                    failures++;
                    $display("FAIL lone_owner step=%0d got %0d want %0d", i, owner, (i == 0) ? 0 : 3);
                end
            end
            if (i > 0) begin
                checks++;
                if (sram_addr !== 10'(10'h300 + i - 1) || sram_wdata !== 16'(16'hA000 + i - 1) || sram_wr !== 1'b1) begin
                    failures++;
                    $display("FAIL lone_cmd step=%0d got addr=%h wdata=%h wr=%b want %h %h 1", i, sram_addr, sram_wdata, sram_wr, 10'(10'h300 + i - 1), 16'(16'hA000 + i - 1));
                end
            end
        end
    endtask

    task automatic test_early_release();
        logic        rv_exp;
        logic [15:0] ed;
        logic        f_t   [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        logic        w_t   [8] = '{0, 1, 1, 1, 0, 0, 0, 0};
        logic [2:0]  g_t   [8] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [1:0]  own_t [8] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        wb_addr = 10'h031; wb_wdata = 16'h7777;
        for (int i = 0; i < 8; i++) begin
            cyc_begin();
            fill_req = f_t[i]; fill_addr = 10'(10'h030 + i);
            wb_req   = w_t[i];
            cyc_sample();
            checks++;
            if ({wb_gnt, fill_gnt, host_gnt} !== g_t[i] || owner !== own_t[i]) begin
                failures++;
                $display("FAIL early_rel step=%0d got gnt=%b owner=%0d want gnt=%b owner=%0d", i, {wb_gnt, fill_gnt, host_gnt}, owner, g_t[i], own_t[i]);
            end
            rv_exp = (rdq.size() > 0) && (rdq[0].due == cyc);
            ed     = rv_exp ? rdq[0].data : 16'h0;
            checks++;
            if (fill_rvalid !== rv_exp || (rv_exp && fill_rdata !== ed)) begin
                failures++;
                $display("FAIL early_return cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h", cyc, fill_rvalid, fill_rdata, rv_exp, ed);
            end
            if (rv_exp) void'(rdq.pop_front());
        end
    endtask

    task automatic test_reset_mid_read();
        cyc_begin();
        fill_req = 1'b1; fill_addr = 10'h005;
        cyc_sample();
        checks++;
        if (fill_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rst_fill_gnt got %b want 1", fill_gnt);
        end
        @(posedge clk);
        #1;
        fill_req = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (sram_addr !== 10'h0 || sram_wr !== 1'b0 || owner !== 2'd0 || fill_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got addr=%h wr=%b owner=%0d rvalid=%b want 0", sram_addr, sram_wr, owner, fill_rvalid);
        end
        rdq.delete();
        for (int i = 0; i < 3; i++) begin
            cyc_begin();
            set_reqs(i == 1, i == 1, i == 1);
            cyc_sample();
            checks++;
            if (fill_rvalid !== 1'b0 || {wb_gnt, fill_gnt, host_gnt} !== 3'b000) begin
                failures++;
                $display("FAIL rst_hold step=%0d got rvalid=%b gnt=%b want 0 000", i, fill_rvalid, {wb_gnt, fill_gnt, host_gnt});
            end
        end
        cyc_begin();
        set_reqs(0, 0, 0);
        rst_n = 1'b1;
        cyc_sample();
    endtask

    task automatic test_simultaneous();
        logic        rv_exp;
        logic [15:0] ed;
        logic [2:0]  eg;
        host_addr = 10'h040; host_wdata = 16'h4444;
        fill_addr = 10'h041;
        wb_addr   = 10'h042; wb_wdata   = 16'h5555;
        for (int i = 0; i < 28; i++) begin
            cyc_begin();
            set_reqs(i < 25, i < 25, i < 25);
            // bursts of 8: host, fill, wb, then host again
            eg = (i < 25) ? (3'b001 << ((i / 8) % 3)) : 3'b000;
            cyc_sample();
            checks++;
            if ({wb_gnt, fill_gnt, host_gnt} !== eg) begin
                failures++;
                $display("FAIL simul_gnt step=%0d got %b want %b", i, {wb_gnt, fill_gnt, host_gnt}, eg);
            end
            rv_exp = (rdq.size() > 0) && (rdq[0].due == cyc);
            ed     = rv_exp ? rdq[0].data : 16'h0;
            checks++;
            if (fill_rvalid !== rv_exp || (rv_exp && fill_rdata !== ed)) begin
                failures++;
                $display("FAIL simul_return cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h", cyc, fill_rvalid, fill_rdata, rv_exp, ed);
            end
            if (rv_exp) void'(rdq.pop_front());
        end
        checks++;
        if (rdq.size() != 0) begin
            failures++;
            $display("FAIL read_drain got %0d outstanding want 0", rdq.size());
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            exp_mem[a]  = 16'(a) ^ 16'hA5A5;
            sram_mem[a] = 16'(a) ^ 16'hA5A5;
        end
        sram_rdata = 16'h0;
        host_addr = '0; host_wdata = '0;
        fill_addr = '0;
        wb_addr   = '0; wb_wdata   = '0;
        test_reset();
        test_host_write();
        test_fill_latency();
        test_raw();
        test_lone_owner();
        test_early_release();
        test_reset_mid_read();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Arbitrates the single-port data SRAM between three requesters:
  - host loader: testbench/preload writes
  - queue fill: reads feeding the queue_array FIFOs
  - write-back: result writes from write_back
- Replaces the static address muxing at the TPU top with a req/gnt handshake, round-robin fairness and a bounded burst lock.
- Drives the SRAM address, write data and write-enable from registers; returns read data to the fill path with a valid strobe.

Parameters:
- DATAW, 16, data word width.
- ADDRW, 10, SRAM address width.
- BURST_MAX, 8, maximum consecutive beats granted to one owner while others wait (at least 1).
- SRAM_RD_LAT, 1, SRAM read latency in cycles, from registered command to read_data valid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- host_req  in  1  host write request.
- host_addr  in  ADDRW  host write address.
- host_wdata  in  DATAW  host write data.
- host_gnt  out  1  host beat accepted this cycle.
- fill_req  in  1  fill read request.
- fill_addr  in  ADDRW  fill read address.
- fill_gnt  out  1  fill beat accepted this cycle.
- fill_rvalid  out  1  fill_rdata valid.
- fill_rdata  out  DATAW  read data returned to fill.
- wb_req  in  1  write-back write request.
- wb_addr  in  ADDRW  write-back address.
- wb_wdata  in  DATAW  write-back data.
- wb_gnt  out  1  write-back beat accepted this cycle.
- sram_addr  out  ADDRW  registered SRAM address.
- sram_wdata  out  DATAW  registered SRAM write data.
- sram_wr  out  1  registered SRAM write enable.
- sram_rdata  in  DATAW  SRAM read data.
- owner  out  2  current owner: 0 none, 1 host, 2 fill, 3 wb.

Behaviour:
- Reset values:
  - all gnt outputs, sram_wr, fill_rvalid = 0
  - sram_addr, sram_wdata, fill_rdata = 0
  - owner = 0
  - rr pointer = host
  - burst count = 0
- Handshake:
  - A beat transfers in a cycle where req && gnt.
  - gnt is combinational from registered state and the current reqs.
  - A requester holds addr/wdata stable while req is high without gnt.
  - A requester may change addr/wdata in the cycle after gnt.
  - At most one gnt is high per cycle.
- Command timing:
  - A beat accepted in cycle N appears on sram_addr/sram_wdata/sram_wr in cycle N+1.
  - sram_wr = 1 for host and wb beats, 0 for fill beats.
  - When no beat is accepted, sram_wr = 0 in the next cycle and the address is held.
- Read return:
  - For a fill beat accepted in cycle N, fill_rvalid = 1 in cycle N+1+SRAM_RD_LAT, with fill_rdata = sram_rdata.
  - Return tracking is a shift register of depth 1+SRAM_RD_LAT, so back-to-back fill beats return back-to-back.
- States:
  - IDLE (owner = 0):
    - Grant the first requester in round-robin order starting at the rr pointer.
    - Move to OWN with burst count = 1 if a beat is accepted.
  - OWN:
    - The owner keeps gnt while its req stays high and burst count < BURST_MAX; burst count increments per beat.
    - Owner req low: release. If another req is pending, grant it in the same cycle (round-robin after the old owner); otherwise go to IDLE.
    - Burst count == BURST_MAX and another req pending: rotate to the next pending requester in the same cycle; burst count = 1.
    - Burst count == BURST_MAX and no other req pending: owner continues; burst count = 1.
    - On every ownership change, rr pointer = requester after the old owner.
- Simultaneous requests from IDLE use rr order. After reset the order is host > fill > wb.
- Ordering:
  - Commands are strictly serialised in accept order.
  - A read accepted after a write to the same address returns the new data.
- Reset mid-operation:
  - All state clears immediately.
  - In-flight read returns are discarded; no fill_rvalid after reset asserts.
  - sram_wr drops to 0 asynchronously.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds outputs stat_host, stat_fill, stat_wb (16 bits each).
  - Each counts accepted beats per requester, saturating at 0xFFFF.
  - Cleared by reset.
  - Adds input stat_clr: synchronous clear of all three, with priority over increment in the same cycle.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package tpu_pkg holds:
  - owner encoding constants OWN_NONE/HOST/FILL/WB (0..3)
  - default ADDRW, DATAW
- Natural sub-module: rr_pick3, a combinational 3-way round-robin picker taking req[2:0] and pointer and returning a one-hot grant.
- Burst counter, return shift register and command registers stay in sram_port_arbiter.

Test Plan:
- Single host write: host_req with addr 0x005, data 0x1234 in cycle 0 → host_gnt in cycle 0; cycle 1 shows sram_addr=0x005, sram_wdata=0x1234, sram_wr=1; cycle 2 shows sram_wr=0.
- Fill read latency: fill_req at addr 0x005 accepted in cycle 10 (SRAM_RD_LAT=1) → fill_rvalid=1 only in cycle 12, fill_rdata=0x1234; 4 back-to-back reads give 4 consecutive rvalid cycles.
- Simultaneous requests: all three reqs held continuously, BURST_MAX=8 → 8 host beats, 8 fill, 8 wb, then host again; never two gnts in one cycle.
- Lone owner: only wb_req held for 20 cycles → 20 consecutive wb_gnt, owner stays 3, no gap at the burst boundary.
- Early release: fill owner drops req after 3 beats while wb_req pending → wb_gnt in that same cycle; owner=3 next cycle.
- Reset mid-read: rst_n low one cycle after a fill accept → no fill_rvalid; all outputs 0; first grant after release goes to host when all reqs are high.
